// File: rtl/debug_step_ctrl.sv
// Purpose: turns debounced key pulses into a single-cycle CPU clock-enable (step / run / burst / halt capture).
// Latency: one cycle from a pulse or cpu_halt to the registered cpu_ce and state; step_count trails cpu_ce by one cycle.
// Backpressure: none; lower-priority or ignored pulses are dropped, never queued.
module debug_step_ctrl #(
    parameter int RUN_DIV   = 50000000,
    parameter int DIV_W     = 26,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             run_pulse,
    input  logic             burst_pulse,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic             running,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_BURST  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // burst_left only ever holds BURST_LEN-1 down to 0
    localparam int                BL_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [BL_W-1:0]   BL_FIRST = BL_W'(BURST_LEN - 1);

    state_t            r_state;
    logic              r_ce;
    logic [DIV_W-1:0]  r_div;
    logic [BL_W-1:0]   r_burst_left;
    logic [CNT_W-1:0]  r_count;

    state_t            w_state_nxt;
    logic              w_ce_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [BL_W-1:0]   w_bl_nxt;

    // State, enable, divider and burst counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_PAUSE;
            r_ce         <= 1'b0;
            r_div        <= '0;
            r_burst_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ce         <= w_ce_nxt;
            r_div        <= w_div_nxt;
            r_burst_left <= w_bl_nxt;
        end
    end

    // Next-state decode; priority is cpu_halt > run > burst > step
    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        w_div_nxt   = r_div;
        w_bl_nxt    = r_burst_left;
        if (r_state != ST_HALTED && cpu_halt) begin
            w_state_nxt = ST_HALTED;
            w_div_nxt   = '0;
            w_bl_nxt    = '0;
        end else begin
            case (r_state)
                ST_PAUSE: begin
                    if (run_pulse) begin
                        w_state_nxt = ST_RUN;
                        w_div_nxt   = '0;
                    end else if (burst_pulse) begin
                        w_state_nxt = ST_BURST;
                        w_ce_nxt    = 1'b1;
                        w_bl_nxt    = BL_FIRST;
                    end else if (step_pulse) begin
                        w_ce_nxt    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_pulse) begin
                        w_state_nxt = ST_PAUSE;
                        w_div_nxt   = '0;
                    end else if (r_div == DIV_LAST) begin
                        w_div_nxt   = '0;
                        w_ce_nxt    = 1'b1;
                    end else begin
                        w_div_nxt   = r_div + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (run_pulse) begin
                        w_state_nxt = ST_PAUSE;
                        w_bl_nxt    = '0;
                    end else if (r_burst_left == '0) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_ce_nxt    = 1'b1;
                        w_bl_nxt    = r_burst_left - 1'b1;
                    end
                end
                default: begin
                    // HALTED: sticky until reset, enable held low
                end
            endcase
        end
    end

    // Count every issued enable, including one already high when halt is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_ce) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign cpu_ce     = r_ce;
    assign state      = r_state;
    assign running    = (r_state == ST_RUN) || (r_state == ST_BURST);
    assign halted     = (r_state == ST_HALTED);
    assign step_count = r_count;

endmodule
